// File: rtl/sdpb_reader_pkg.sv
// rtl/sdpb_reader_pkg.sv - shared types and width helpers for the frame-buffer stream reader
package sdpb_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Length must represent a full-buffer transfer, hence one bit wider than the address.
  function automatic int len_width(input int depth);
    return addr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/sdpb_reader_fifo.sv
// rtl/sdpb_reader_fifo.sv - show-ahead output FIFO with occupancy count
module sdpb_reader_fifo #(
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_WIDTH_B = 32,
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH_B-1:0] wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH_B-1:0] rd_data,
  output logic                    empty,
  output logic [CW-1:0]           count
);

  logic [DATA_WIDTH_B-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic                    do_rd;
  logic                    full;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Credit-based issue upstream guarantees a free slot for every write.
      assert (!(wr_en && full));
      if (wr_en) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({wr_en, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdpb_stream_reader.sv
// rtl/sdpb_stream_reader.sv - walks a word range of BRAM port B and streams it out with valid/ready
module sdpb_stream_reader
  import sdpb_reader_pkg::*;
#(
  parameter int ADDRESS_DEPTH_B = 512,
  parameter int DATA_WIDTH_B    = 32,
  parameter int READ_LATENCY    = 2,
  parameter int FIFO_DEPTH      = 4,
  localparam int AW = addr_width(ADDRESS_DEPTH_B),
  localparam int LW = len_width(ADDRESS_DEPTH_B)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AW-1:0]           base_addr,
  input  logic [LW-1:0]           length,
  output logic                    busy,
  output logic                    done,
  output logic                    ceb,
  output logic [AW-1:0]           adb,
  output logic                    oce,
  output logic                    resetb,
  input  logic [DATA_WIDTH_B-1:0] bram_dout,
  output logic [DATA_WIDTH_B-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                  state;
  state_t                  state_nx;
  logic [AW-1:0]           rd_addr;
  logic [LW-1:0]           len_q;
  logic [LW-1:0]           issued;
  logic [LW-1:0]           delivered;
  logic [LW-1:0]           last_idx;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic [CW-1:0]           occupancy;
  logic [DATA_WIDTH_B-1:0] fifo_head;
  logic                    fifo_empty;
  logic                    accept;
  logic                    issue;
  logic                    pop;
  logic                    credit_ok;
  int                      inflight;

  assign accept   = (state == IDLE) && start;
  assign last_idx = len_q - LW'(1);
  assign pop      = m_valid && m_ready;

  // Registered counts only: a word popped this cycle frees its credit next cycle.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + int'(rd_pipe[i]);
    end
  end

  assign credit_ok = (inflight + int'(occupancy)) < FIFO_DEPTH;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (length == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if ((issued < len_q) && credit_ok) begin
          issue = 1'b1;
          if (issued == last_idx) begin
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (delivered == last_idx)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr   <= '0;
      len_q     <= '0;
      issued    <= '0;
      delivered <= '0;
      rd_pipe   <= '0;
    end else begin
      // Valid shift register mirrors the BRAM pipeline; its tail marks dout as a real read.
      rd_pipe[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      if (accept) begin
        rd_addr   <= base_addr;
        len_q     <= length;
        issued    <= '0;
        delivered <= '0;
      end
      if (issue) begin
        rd_addr <= (rd_addr == AW'(ADDRESS_DEPTH_B - 1)) ? '0 : rd_addr + AW'(1);
        issued  <= issued + LW'(1);
      end
      if (pop) begin
        delivered <= delivered + LW'(1);
      end
    end
  end

  sdpb_reader_fifo #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .DATA_WIDTH_B(DATA_WIDTH_B)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (rd_pipe[READ_LATENCY-1]),
    .wr_data(bram_dout),
    .rd_en  (pop),
    .rd_data(fifo_head),
    .empty  (fifo_empty),
    .count  (occupancy)
  );

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign ceb     = issue;
  assign adb     = rd_addr;
  assign oce     = !reset;
  assign resetb  = reset;
  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? fifo_head : '0;
  assign m_last  = m_valid && (delivered == last_idx);

endmodule
